regfile_wb_scheduler: RTL and testbench

//  Owns the single write port (WE3/A3/WD3) of the 32x32 register file. It shares

---
 rtl/regfile_wb_scheduler.sv | 133 +++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Write-port arbiter for the register file: the pipeline writeback has priority over one
// long-latency unit. Tracks long-latency destinations and flags decode hazards and starvation.
module regfile_wb_scheduler #(
  parameter int ADDRESS_WIDTH   = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          pipe_we_i,
  input  logic [ADDRESS_WIDTH-1:0]      pipe_rd_i,
  input  logic [DATA_WIDTH-1:0]         pipe_wd_i,
  input  logic                          ll_valid_i,
  output logic                          ll_ready_o,
  input  logic [ADDRESS_WIDTH-1:0]      ll_rd_i,
  input  logic [DATA_WIDTH-1:0]         ll_wd_i,
  input  logic                          issue_i,
  input  logic [ADDRESS_WIDTH-1:0]      dec_rs1_i,
  input  logic [ADDRESS_WIDTH-1:0]      dec_rs2_i,
  input  logic [ADDRESS_WIDTH-1:0]      dec_rd_i,
  output logic                          hazard_o,
  output logic                          stall_o,
  output logic                          we3_o,
  output logic [ADDRESS_WIDTH-1:0]      a3_o,
  output logic [DATA_WIDTH-1:0]         wd3_o,
  output logic [(2**ADDRESS_WIDTH)-1:0] pending_o
);

  localparam int NREG  = 2**ADDRESS_WIDTH;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  logic             pw;
  logic             accept;
  logic             issue_fire;
  logic             hazard;
  logic [NREG-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             stall_q, stall_d;

  // Port arbitration: an effective pipeline write always owns the port.
  assign pw         = pipe_we_i && (pipe_rd_i != '0);
  assign ll_ready_o = !pw;
  assign accept     = ll_valid_i && ll_ready_o;

  always_comb begin
    we3_o = 1'b0;
    a3_o  = '0;
    wd3_o = '0;
    if (pw) begin
      we3_o = 1'b1;
      a3_o  = pipe_rd_i;
      wd3_o = pipe_wd_i;
    end else if (ll_valid_i && (ll_rd_i != '0)) begin
      we3_o = 1'b1;
      a3_o  = ll_rd_i;
      wd3_o = ll_wd_i;
    end
  end

  // A same-cycle accept frees a slot, so a full unit does not block that issue.
  always_comb begin
    hazard = pending_q[dec_rs1_i] || pending_q[dec_rs2_i];
    if (issue_i && pending_q[dec_rd_i])
      hazard = 1'b1;
    if (issue_i && (count_q == CNT_MAX) && !accept)
      hazard = 1'b1;
  end

  assign hazard_o   = hazard;
  assign issue_fire = issue_i && !hazard;

  always_comb begin
    pending_d = pending_q;
    if (accept)
      pending_d[ll_rd_i] = 1'b0;
    if (issue_fire && (dec_rd_i != '0))
      pending_d[dec_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    if (issue_fire && !accept) begin
      if (count_q != CNT_MAX)
        count_d = count_q + CNT_W'(1);
    end else if (accept && !issue_fire) begin
      if (count_q != '0)
        count_d = count_q - CNT_W'(1);
    end
  end

  // Starvation counter saturates at the limit; stall holds until the result is taken.
  always_comb begin
    starve_d = starve_q;
    if (accept || !ll_valid_i)
      starve_d = '0;
    else if (starve_q != STV_MAX)
      starve_d = starve_q + STV_W'(1);
    stall_d = (starve_d == STV_MAX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
    end
  end

  assign stall_o   = stall_q;
  assign pending_o = pending_q;

  a_no_same_dest: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ll_valid_i && pw && (pipe_rd_i == ll_rd_i)));
  a_x0_clear: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pending_q[0] == 1'b0);
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CNT_MAX);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(accept && (count_q == '0)));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration, scoreboard, full-unit,
// starvation and asynchronous reset cases with hand-computed expectations.
module tb_regfile_wb_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_we;
  logic [AW-1:0] pipe_rd;
  logic [DW-1:0] pipe_wd;
  logic          ll_valid;
  logic          ll_ready;
  logic [AW-1:0] ll_rd;
  logic [DW-1:0] ll_wd;
  logic          issue;
  logic [AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic          hazard, stall, we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [31:0]   pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4), .STARVE_LIMIT(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_wd_i(pipe_wd),
    .ll_valid_i(ll_valid), .ll_ready_o(ll_ready), .ll_rd_i(ll_rd), .ll_wd_i(ll_wd),
    .issue_i(issue), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2), .dec_rd_i(dec_rd),
    .hazard_o(hazard), .stall_o(stall),
    .we3_o(we3), .a3_o(a3), .wd3_o(wd3), .pending_o(pending)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_wd = '0;
    issue = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  task automatic issue_one(input logic [AW-1:0] rd);
    issue = 1'b1;
    dec_rd = rd;
    #1;
    chk("issue_no_hazard", hazard, 1'b0);
    tick();
    issue = 1'b0;
    dec_rd = '0;
  endtask

  task automatic accept_one(input logic [AW-1:0] rd);
    ll_valid = 1'b1;
    ll_rd = rd;
    ll_wd = 32'h100 + 32'(rd);
    #1;
    chk("accept_ready", ll_ready, 1'b1);
    tick();
    ll_valid = 1'b0;
    ll_rd = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_pending", pending, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_hazard", hazard, 1'b0);
    chk("rst_we3", we3, 1'b0);
    chk("rst_ll_ready", ll_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: pipeline write, LL idle
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEAD;
    #1;
    chk("t1_we3", we3, 1'b1);
    chk("t1_a3", a3, 5'd5);
    chk("t1_wd3", wd3, 32'hDEAD);
    chk("t1_ll_ready", ll_ready, 1'b0);
    tick();
    idle();

    // T2: pipe write to x0 yields the port to the LL result
    issue_one(5'd7);
    chk("t2_pending7", pending, 32'h80);
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'h55;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_wd = 32'h42;
    #1;
    chk("t2_we3", we3, 1'b1);
    chk("t2_a3", a3, 5'd7);
    chk("t2_wd3", wd3, 32'h42);
    chk("t2_ll_ready", ll_ready, 1'b1);
    tick();
    idle();
    #1;
    chk("t2_cleared", pending, 32'h0);

    // T3: RAW on a pending register until its result is accepted
    issue_one(5'd9);
    dec_rs2 = 5'd9;
    #1;
    chk("t3_raw", hazard, 1'b1);
    ll_valid = 1'b1; ll_rd = 5'd9; ll_wd = 32'h99;
    #1;
    chk("t3_raw_during_accept", hazard, 1'b1);
    tick();
    ll_valid = 1'b0;
    #1;
    chk("t3_pending_clear", pending, 32'h0);
    chk("t3_no_hazard", hazard, 1'b0);
    idle();

    // T4: full unit; a same-cycle accept lets the fifth issue through
    issue_one(5'd1);
    issue_one(5'd2);
    issue_one(5'd4);
    issue_one(5'd6);
    chk("t4_pending4", pending, 32'h56);
    issue = 1'b1; dec_rd = 5'd8;
    #1;
    chk("t4_full", hazard, 1'b1);
    ll_valid = 1'b1; ll_rd = 5'd1; ll_wd = 32'h11;
    #1;
    chk("t4_full_with_accept", hazard, 1'b0);
    tick();
    ll_valid = 1'b0; ll_rd = '0;
    dec_rd = 5'd11;
    #1;
    chk("t4_count_still_full", hazard, 1'b1);
    chk("t4_pending_swap", pending, 32'h154);
    dec_rd = 5'd4;
    issue = 1'b1;
    #1;
    chk("t4_waw", hazard, 1'b1);
    idle();
    accept_one(5'd2);
    accept_one(5'd4);
    accept_one(5'd6);
    accept_one(5'd8);
    chk("t4_drained", pending, 32'h0);

    // T5: starvation bubble
    issue_one(5'd10);
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h33;
    ll_valid = 1'b1; ll_rd = 5'd10; ll_wd = 32'hAA;
    #1;
    chk("t5_ll_blocked", ll_ready, 1'b0);
    chk("t5_a3_pipe", a3, 5'd3);
    chk("t5_stall0", stall, 1'b0);
    tick();
    chk("t5_stall1", stall, 1'b0);
    tick();
    chk("t5_stall2", stall, 1'b0);
    tick();
    chk("t5_stall3", stall, 1'b1);
    pipe_we = 1'b0;
    #1;
    chk("t5_ll_we3", we3, 1'b1);
    chk("t5_ll_a3", a3, 5'd10);
    chk("t5_ll_wd3", wd3, 32'hAA);
    tick();
    idle();
    chk("t5_stall_drop", stall, 1'b0);
    chk("t5_pending", pending, 32'h0);

    // T6: asynchronous reset mid-run
    issue_one(5'd3);
    issue_one(5'd9);
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'h5;
    ll_valid = 1'b1; ll_rd = 5'd3; ll_wd = 32'h3;
    tick();
    tick();
    tick();
    chk("t6_pre_stall", stall, 1'b1);
    chk("t6_pre_pending", pending, 32'h208);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pending", pending, 32'h0);
    chk("t6_rst_stall", stall, 1'b0);
    idle();
    dec_rs1 = 5'd3; dec_rs2 = 5'd9;
    #1;
    chk("t6_rst_we3", we3, 1'b0);
    chk("t6_rst_hazard", hazard, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    issue_one(5'd12);
    issue_one(5'd13);
    issue_one(5'd14);
    issue_one(5'd15);
    issue = 1'b1; dec_rd = 5'd16;
    #1;
    chk("t6_count_reset_full", hazard, 1'b1);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
